// File: rtl/pmu_pwr_seq.sv
// Power-domain sequencer for one switchable core domain: timed, acknowledged and
// abortable power-down / power-up walk with timeout-to-error reporting.
module pmu_pwr_seq #(
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             pmu_clk,
  input  logic             pad_cpu_rst,
  input  logic             sleep_req,
  input  logic             wake_req,
  input  logic             err_clr,
  input  logic [CNT_W-1:0] cfg_dly,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             pwr_sw_ack,
  output logic             pwr_sw_en,
  output logic             iso_en,
  output logic             dom_rst_b,
  output logic             dom_off,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_err
);

  typedef enum logic [3:0] {
    S_ON          = 4'd0,
    S_RST_ASSERT  = 4'd1,
    S_ISO_ON      = 4'd2,
    S_SW_OFF_WAIT = 4'd3,
    S_OFF         = 4'd4,
    S_SW_ON_WAIT  = 4'd5,
    S_ISO_OFF     = 4'd6,
    S_RST_RELEASE = 4'd7,
    S_ERR         = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [TO_W-1:0]   r_cnt;
  logic [CNT_W-1:0]  r_dly;
  logic [TO_W-1:0]   r_to;
  logic              w_dwell_done;
  logic              w_timeout;
  logic              w_capture;
  logic              w_state_chg;
  logic              w_done_next;
  logic              w_pwr_next;
  logic              w_iso_next;
  logic              w_rstb_next;

  assign w_dwell_done = (r_cnt == TO_W'(r_dly));
  assign w_timeout    = (r_to != '0) && (r_cnt == (r_to - TO_W'(1)));
  assign w_state_chg  = (w_state_next != r_state);

  // Timing config is frozen for the whole sequence once it leaves a resting state.
  assign w_capture = ((r_state == S_ON || r_state == S_OFF) && w_state_chg) ||
                     (r_state == S_ERR && err_clr);

  assign w_done_next = (r_state == S_RST_RELEASE && w_state_next == S_ON) ||
                       (r_state == S_SW_OFF_WAIT && w_state_next == S_OFF);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ON: begin
        if (sleep_req && !wake_req) w_state_next = S_RST_ASSERT;
      end
      S_RST_ASSERT: begin
        if (wake_req)          w_state_next = S_RST_RELEASE;
        else if (w_dwell_done) w_state_next = S_ISO_ON;
      end
      S_ISO_ON: begin
        if (wake_req)          w_state_next = S_ISO_OFF;
        else if (w_dwell_done) w_state_next = S_SW_OFF_WAIT;
      end
      S_SW_OFF_WAIT: begin
        if (wake_req)         w_state_next = S_SW_ON_WAIT;
        else if (!pwr_sw_ack) w_state_next = S_OFF;
        else if (w_timeout)   w_state_next = S_ERR;
      end
      S_OFF: begin
        if (wake_req) w_state_next = S_SW_ON_WAIT;
      end
      S_SW_ON_WAIT: begin
        if (pwr_sw_ack)     w_state_next = S_ISO_OFF;
        else if (w_timeout) w_state_next = S_ERR;
      end
      S_ISO_OFF: begin
        if (w_dwell_done) w_state_next = S_RST_RELEASE;
      end
      S_RST_RELEASE: begin
        if (w_dwell_done) w_state_next = S_ON;
      end
      S_ERR: begin
        if (err_clr) w_state_next = S_SW_ON_WAIT;
      end
      default: w_state_next = S_ON;
    endcase
  end

  // Rail controls are decoded from the state being entered so they register with it.
  always_comb begin
    w_pwr_next  = 1'b1;
    w_iso_next  = 1'b0;
    w_rstb_next = 1'b1;
    case (w_state_next)
      S_RST_ASSERT:  begin w_pwr_next = 1'b1; w_iso_next = 1'b0; w_rstb_next = 1'b0; end
      S_ISO_ON:      begin w_pwr_next = 1'b1; w_iso_next = 1'b1; w_rstb_next = 1'b0; end
      S_SW_OFF_WAIT: begin w_pwr_next = 1'b0; w_iso_next = 1'b1; w_rstb_next = 1'b0; end
      S_OFF:         begin w_pwr_next = 1'b0; w_iso_next = 1'b1; w_rstb_next = 1'b0; end
      S_SW_ON_WAIT:  begin w_pwr_next = 1'b1; w_iso_next = 1'b1; w_rstb_next = 1'b0; end
      S_ISO_OFF:     begin w_pwr_next = 1'b1; w_iso_next = 1'b0; w_rstb_next = 1'b0; end
      S_RST_RELEASE: begin w_pwr_next = 1'b1; w_iso_next = 1'b0; w_rstb_next = 1'b1; end
      S_ERR:         begin w_pwr_next = 1'b1; w_iso_next = 1'b1; w_rstb_next = 1'b0; end
      default:       begin w_pwr_next = 1'b1; w_iso_next = 1'b0; w_rstb_next = 1'b1; end
    endcase
  end

  always_ff @(posedge pmu_clk) begin
    if (pad_cpu_rst) begin
      r_state   <= S_ON;
      r_cnt     <= '0;
      r_dly     <= '0;
      r_to      <= '0;
      pwr_sw_en <= 1'b1;
      iso_en    <= 1'b0;
      dom_rst_b <= 1'b1;
      dom_off   <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_chg)      r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + TO_W'(1);
      if (w_capture) begin
        r_dly <= cfg_dly;
        r_to  <= cfg_timeout;
      end
      pwr_sw_en <= w_pwr_next;
      iso_en    <= w_iso_next;
      dom_rst_b <= w_rstb_next;
      dom_off   <= (w_state_next == S_OFF);
      seq_busy  <= !(w_state_next == S_ON || w_state_next == S_OFF || w_state_next == S_ERR);
      seq_done  <= w_done_next;
      seq_err   <= (w_state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// Self-checking bench for pmu_pwr_seq: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based behavioural model.
module tb_pmu_pwr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sleep = 1'b0;
  logic        wake = 1'b0;
  logic        eclr = 1'b0;
  logic [7:0]  dly = 8'd0;
  logic [15:0] tmo = 16'd0;
  logic        ack = 1'b1;
  logic        pwr_sw_en, iso_en, dom_rst_b, dom_off, seq_busy, seq_done, seq_err;
  logic [6:0]  obs;

  int n_checks = 0;
  int n_errors = 0;

  bit       ack_follow = 1'b1;
  bit [2:0] ack_lat = 3'd0;
  bit [7:0] hist = 8'hff;

  pmu_pwr_seq #(.CNT_W(8), .TO_W(16)) dut (
    .pmu_clk(clk), .pad_cpu_rst(rst), .sleep_req(sleep), .wake_req(wake),
    .err_clr(eclr), .cfg_dly(dly), .cfg_timeout(tmo), .pwr_sw_ack(ack),
    .pwr_sw_en(pwr_sw_en), .iso_en(iso_en), .dom_rst_b(dom_rst_b),
    .dom_off(dom_off), .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  assign obs = {pwr_sw_en, iso_en, dom_rst_b, dom_off, seq_busy, seq_done, seq_err};

  // Reference model: phase plus the cycle it was entered; elapsed time replaces a counter.
  localparam int M_ON = 0, M_RA = 1, M_IO = 2, M_SOW = 3, M_OFF = 4,
                 M_SONW = 5, M_IOF = 6, M_RR = 7, M_ERR = 8;
  logic [2:0] rails [9] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b010,
                            3'b110, 3'b100, 3'b101, 3'b110};
  int m_ph = M_ON, m_entry = 0, m_dly = 0, m_to = 0, cyc = 0;
  bit m_done = 1'b0;

  always @(posedge clk) begin : model
    int nxt, el;
    bit done, cap;
    cyc = cyc + 1;
    el  = cyc - m_entry - 1;
    nxt = m_ph; done = 1'b0; cap = 1'b0;
    if (rst) begin
      m_ph = M_ON; m_entry = cyc; m_done = 1'b0; m_dly = 0; m_to = 0;
    end else begin
      case (m_ph)
        M_ON:   if (sleep && !wake) begin nxt = M_RA; cap = 1'b1; end
        M_RA:   if (wake) nxt = M_RR; else if (el == m_dly) nxt = M_IO;
        M_IO:   if (wake) nxt = M_IOF; else if (el == m_dly) nxt = M_SOW;
        M_SOW:  if (wake) nxt = M_SONW;
                else if (!ack) begin nxt = M_OFF; done = 1'b1; end
                else if (m_to != 0 && el == m_to - 1) nxt = M_ERR;
        M_OFF:  if (wake) begin nxt = M_SONW; cap = 1'b1; end
        M_SONW: if (ack) nxt = M_IOF;
                else if (m_to != 0 && el == m_to - 1) nxt = M_ERR;
        M_IOF:  if (el == m_dly) nxt = M_RR;
        M_RR:   if (el == m_dly) begin nxt = M_ON; done = 1'b1; end
        M_ERR:  if (eclr) begin nxt = M_SONW; cap = 1'b1; end
        default: nxt = M_ON;
      endcase
      if (cap) begin m_dly = int'(dly); m_to = int'(tmo); end
      if (nxt != m_ph) m_entry = cyc;
      m_ph = nxt; m_done = done;
    end
  end

  function automatic logic [6:0] exp_vec();
    return {rails[m_ph], m_ph == M_OFF,
            !(m_ph == M_ON || m_ph == M_OFF || m_ph == M_ERR), m_done, m_ph == M_ERR};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (ack_follow) begin
      hist = {hist[6:0], pwr_sw_en};
      ack  = hist[ack_lat];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 7'b1010000) begin
      n_errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 7'b1010000);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs !== 7'b1010000 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_idle got=%b want=%b", obs, 7'b1010000);
    end
  endtask

  task automatic test_power_down();
    logic [6:0] want [10];
    want = '{7'b1000100, 7'b1000100, 7'b1000100, 7'b1100100, 7'b1100100,
             7'b1100100, 7'b0100100, 7'b0100100, 7'b0101010, 7'b0101000};
    dly = 8'd2; tmo = 16'd10; ack_follow = 1'b1; ack_lat = 3'd1;
    sleep = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (obs !== want[k-1] || obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL power_down edge=%0d got=%b want=%b model=%b", k, obs, want[k-1], exp_vec());
      end
    end
  endtask

  task automatic test_power_up();
    logic [6:0] want [8];
    want = '{7'b1100100, 7'b1100100, 7'b1100100, 7'b1100100,
             7'b1000100, 7'b1010100, 7'b1010010, 7'b1010000};
    dly = 8'd0; ack_lat = 3'd3; sleep = 1'b0;
    wake = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (obs !== want[k-1] || obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL power_up edge=%0d got=%b want=%b model=%b", k, obs, want[k-1], exp_vec());
      end
    end
    wake = 1'b0;
  endtask

  task automatic test_timeout();
    ack_follow = 1'b0; ack = 1'b1; dly = 8'd0; tmo = 16'd5;
    sleep = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec() || (k == 7 && obs !== 7'b0100100) || (k == 8 && obs !== 7'b1100001)) begin
        n_errors++;
        $display("FAIL timeout edge=%0d got=%b model=%b", k, obs, exp_vec());
      end
    end
    sleep = 1'b0; wake = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== 7'b1100001 || obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL err_hold got=%b want=%b", obs, 7'b1100001);
      end
    end
    wake = 1'b0; eclr = 1'b1; dly = 8'd1;
    tick();
    eclr = 1'b0;
    n_checks++;
    if (obs !== 7'b1100100 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL err_clr got=%b want=%b", obs, 7'b1100100);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL err_recover step=%0d got=%b model=%b", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (obs !== 7'b1010000) begin
      n_errors++;
      $display("FAIL err_back_on got=%b want=%b", obs, 7'b1010000);
    end
  endtask

  task automatic test_abort();
    bit sw_dropped = 1'b0;
    ack_follow = 1'b1; ack_lat = 3'd0; dly = 8'd3; tmo = 16'd10;
    sleep = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 7) wake = 1'b1;
      tick();
      if (pwr_sw_en !== 1'b1) sw_dropped = 1'b1;
      n_checks++;
      if (obs !== exp_vec() || (k == 7 && obs !== 7'b1000100) || (k == 15 && obs !== 7'b1010010)) begin
        n_errors++;
        $display("FAIL abort edge=%0d got=%b model=%b", k, obs, exp_vec());
      end
    end
    n_checks++;
    if (sw_dropped) begin
      n_errors++;
      $display("FAIL abort_switch got=dropped want=held_on");
    end
    sleep = 1'b0; wake = 1'b0;
  endtask

  task automatic test_timeout_disabled();
    ack_follow = 1'b0; ack = 1'b1; dly = 8'd0; tmo = 16'd0;
    sleep = 1'b1;
    for (int k = 1; k <= 70000; k++) begin
      tick();
      if (k >= 3 && (k % 2000 == 0 || k == 70000)) begin
        n_checks++;
        if (obs !== 7'b0100100 || obs !== exp_vec()) begin
          n_errors++;
          $display("FAIL no_timeout cycle=%0d got=%b want=%b", k, obs, 7'b0100100);
        end
      end
    end
    sleep = 1'b0; wake = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec() || (k == 4 && obs !== 7'b1010010)) begin
        n_errors++;
        $display("FAIL no_timeout_exit edge=%0d got=%b model=%b", k, obs, exp_vec());
      end
    end
    wake = 1'b0;
  endtask

  task automatic test_reset_mid();
    ack_follow = 1'b1; ack_lat = 3'd0; dly = 8'd0; tmo = 16'd8;
    sleep = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_checks++;
    if (obs !== 7'b0101000 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL reach_off got=%b want=%b", obs, 7'b0101000);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 7'b1010000) begin
      n_errors++;
      $display("FAIL reset_in_off got=%b want=%b", obs, 7'b1010000);
    end
    rst = 1'b0; sleep = 1'b0;
    tick();
    n_checks++;
    if (obs !== 7'b1010000 || obs !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_settle got=%b want=%b", obs, 7'b1010000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5000; i++) begin
      if (i % 150 == 0) begin
        ack_follow = ($urandom_range(0, 3) != 0);
        ack_lat    = 3'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 19) == 0) sleep = ~sleep;
      if ($urandom_range(0, 29) == 0) wake = ~wake;
      eclr = ($urandom_range(0, 15) == 0);
      dly  = 8'($urandom_range(0, 4));
      tmo  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      rst  = ($urandom_range(0, 599) == 0);
      if (!ack_follow && $urandom_range(0, 3) == 0) ack = ~ack;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cycle=%0d got=%b model=%b", i, obs, exp_vec());
      end
    end
    rst = 1'b0; eclr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_power_down();
    test_power_up();
    test_timeout();
    test_abort();
    test_timeout_disabled();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
